// File: rtl/bram_stream_bridge_if.sv
// Valid/ready word stream shared by the bridge input and output.
// The master drives data/valid and the slave drives ready.
interface bram_stream_bridge_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/bram_stream_bridge.sv
// Stream -> input BRAM, fixed core wait, result BRAM -> stream.
// Optional BRIDGE_CHECKSUM_EN adds a running sum of drained words.
module bram_stream_bridge #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BLOCK_LEN = 1024,
  parameter int WAIT_CYC  = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  output logic                busy,
  output logic                done,
  bram_stream_bridge_if.slave  s_if,
  bram_stream_bridge_if.master m_if,
  output logic [ADDR_W-1:0]   a_addr,
  output logic [DATA_W-1:0]   a_din,
  output logic [DATA_W/8-1:0] a_we,
  output logic                a_en,
  output logic [ADDR_W-1:0]   b_addr,
  output logic                b_en,
`ifdef BRIDGE_CHECKSUM_EN
  output logic [DATA_W-1:0]   checksum,
`endif
  input  logic [DATA_W-1:0]   b_dout
);

  localparam int CW = ADDR_W + 1;
  localparam int WW = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] LEN   = CW'(BLOCK_LEN);
  localparam logic [CW-1:0] LAST  = CW'(BLOCK_LEN - 1);
  localparam logic [WW-1:0] WLOAD = WW'(WAIT_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [WW-1:0] wait_q, wait_d;

  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [DATA_W-1:0] a_din_q, a_din_d;
  logic              a_en_q, a_en_d;
  logic              done_q, done_d;

  logic                   inflight_q, inflight_d;
  logic [1:0][DATA_W-1:0] fifo_q, fifo_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             cnt_q, cnt_d;

  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  occ;
  logic [DATA_W-1:0] head;

  assign head = fifo_q[rd_ptr_q];
  assign push = inflight_q;
  assign pop  = (cnt_q != 2'd0) && m_if.ready;

  // A slot freed by this cycle's pop can take the read issued now,
  // which keeps one word per cycle flowing with at most 2 in flight.
  assign occ = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};

  assign issue = (state_q == S_DRAIN)
              && (rd_cnt_q < LEN)
              && (occ < 3'd2);

  always_comb begin
    state_d    = state_q;
    wr_cnt_d   = wr_cnt_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    wait_d     = wait_q;
    a_addr_d   = a_addr_q;
    a_din_d    = a_din_q;
    a_en_d     = 1'b0;
    done_d     = 1'b0;
    inflight_d = 1'b0;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (s_if.valid) begin
          a_en_d   = 1'b1;
          a_addr_d = wr_cnt_q[ADDR_W-1:0];
          a_din_d  = s_if.data;
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q == LAST) begin
            state_d = S_WAIT;
            wait_d  = WLOAD;
          end
        end
      end
      S_WAIT: begin
        wait_d = wait_q - WW'(1);
        if (wait_q == WW'(1)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && (out_cnt_q == LAST)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      rd_cnt_d   = rd_cnt_q + CW'(1);
      inflight_d = 1'b1;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = b_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end

    if (pop) begin
      out_cnt_d = out_cnt_q + CW'(1);
      rd_ptr_d  = ~rd_ptr_q;
    end

    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      wait_q     <= '0;
      a_addr_q   <= '0;
      a_din_q    <= '0;
      a_en_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      fifo_q     <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wait_q     <= wait_d;
      a_addr_q   <= a_addr_d;
      a_din_q    <= a_din_d;
      a_en_q     <= a_en_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef BRIDGE_CHECKSUM_EN
  logic [DATA_W-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if ((state_q == S_IDLE) && start) begin
      cks_d = '0;
    end else if (pop) begin
      cks_d = cks_q + head;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`endif

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign s_if.ready = (state_q == S_LOAD);
  assign m_if.valid = (cnt_q != 2'd0);
  assign m_if.data  = head;
  assign a_addr     = a_addr_q;
  assign a_din      = a_din_q;
  assign a_en       = a_en_q;
  assign a_we       = {(DATA_W/8){a_en_q}};
  assign b_en       = issue;
  assign b_addr     = rd_cnt_q[ADDR_W-1:0];

endmodule
